// File: rtl/decode_operand_sequencer.sv
// decode_operand_sequencer: operand byte queue presenting a displacement+immediate window; clock/reset/flush, fetch push, req handshake, win window out, occupancy/length_error/stall_cycles status; DECODE_SEQ_STALL_COUNT_EN enables the WAIT-cycle stall counter
module decode_operand_sequencer #(
  parameter int QUEUE_DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] fetch_bytes,
  input  logic [2:0]  fetch_count,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        displacement_is_present,
  input  logic [3:0]  displacement_length,
  input  logic        immediate_is_present,
  input  logic [3:0]  immediate_length,
  output logic        win_valid,
  input  logic        win_ready,
  output logic [63:0] window,
  output logic [5:0]  occupancy,
  output logic        length_error,
  output logic [15:0] stall_cycles
);
  localparam int QW = 8 * QUEUE_DEPTH;
  typedef enum logic [1:0] {IDLE, WAIT, PRESENT} state_t;
  state_t state_q, state_d;
  logic [QW-1:0] buf_q, buf_d;
  logic [5:0] occ_q, occ_d, rem;
  logic [3:0] need_q, need_d, need_new, pop;
  logic [63:0] window_q, window_d;
  logic [31:0] push_bytes;
  logic [2:0] push_n;
  logic err_q, err_d, push, cnt_ok, illegal, hs;
  function automatic logic [3:0] field_bytes(input logic p, input logic [3:0] l);
    return !p ? 4'd0 : l[0] ? 4'd1 : l[1] ? 4'd2 : (l[2] | l[3]) ? 4'd4 : 4'd0;
  endfunction
  always_comb begin
    cnt_ok = fetch_count != 3'd0 && fetch_count <= 3'd4;
    push = fetch_valid && fetch_ready && cnt_ok && !flush;
    push_n = push ? fetch_count : 3'd0;
    push_bytes = push ? fetch_bytes & ~(32'hFFFF_FFFF << {fetch_count, 3'b000}) : 32'd0;
    illegal = (displacement_is_present && !$onehot(displacement_length)) ||
              (immediate_is_present && !$onehot(immediate_length));
    need_new = field_bytes(displacement_is_present, displacement_length) +
               field_bytes(immediate_is_present, immediate_length);
    hs = req_valid && req_ready && !flush;
    pop = (state_q == PRESENT && win_ready && !flush) ? need_q : 4'd0;
    rem = occ_q - 6'(pop);
    occ_d = flush ? 6'd0 : rem + 6'(push_n);
    buf_d = flush ? '0 : (buf_q >> {pop, 3'b000}) | (QW'(push_bytes) << {rem, 3'b000});
    need_d = (hs && !illegal) ? need_new : need_q;
    state_d = state_q;
    if (flush) state_d = IDLE;
    else if (state_q == IDLE && hs && !illegal) state_d = (occ_q + 6'(push_n) >= 6'(need_new)) ? PRESENT : WAIT;
    else if (state_q == WAIT && occ_q >= 6'(need_q)) state_d = PRESENT;
    else if (state_q == PRESENT && win_ready) state_d = IDLE;
    err_d = !flush && ((hs && illegal) || (fetch_valid && !cnt_ok));
    window_d = (state_q == PRESENT && state_d == PRESENT) ? window_q : buf_d[63:0];
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      buf_q <= '0;
      occ_q <= '0;
      need_q <= '0;
      window_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q <= buf_d;
      occ_q <= occ_d;
      need_q <= need_d;
      window_q <= window_d;
      err_q <= err_d;
    end
  end
  assign fetch_ready = occ_q <= 6'(QUEUE_DEPTH - 4);
  assign req_ready = state_q == IDLE;
  assign win_valid = state_q == PRESENT;
  assign window = window_q;
  assign occupancy = occ_q;
  assign length_error = err_q;
`ifdef DECODE_SEQ_STALL_COUNT_EN
  logic [15:0] stall_q, stall_d;
  always_comb stall_d = flush ? 16'd0 : (state_q == WAIT && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
  always_ff @(posedge clock) begin
    if (reset) stall_q <= '0;
    else stall_q <= stall_d;
  end
  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 16'h0000;
`endif
endmodule

// File: tb/tb_decode_operand_sequencer.sv
// tb_decode_operand_sequencer: randomized scoreboard bench for decode_operand_sequencer
module tb_decode_operand_sequencer;
  localparam int DEPTH = 16;
  logic clock = 1'b0;
  logic reset, flush, fetch_valid, fetch_ready, req_valid, req_ready;
  logic [31:0] fetch_bytes;
  logic [2:0] fetch_count;
  logic displacement_is_present, immediate_is_present;
  logic [3:0] displacement_length, immediate_length;
  logic win_valid, win_ready, length_error;
  logic [63:0] window;
  logic [5:0] occupancy;
  logic [15:0] stall_cycles;
  int checks = 0;
  int failures = 0;
  byte unsigned mq[$];
  int sb[$];
  int pop_n = 0;
  bit exp_err = 0;
  bit hold_prev = 0;
  logic [63:0] prev_win;
  int late = 0;
  decode_operand_sequencer #(.QUEUE_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_bytes(fetch_bytes), .fetch_count(fetch_count),
    .req_valid(req_valid), .req_ready(req_ready),
    .displacement_is_present(displacement_is_present), .displacement_length(displacement_length),
    .immediate_is_present(immediate_is_present), .immediate_length(immediate_length),
    .win_valid(win_valid), .win_ready(win_ready), .window(window),
    .occupancy(occupancy), .length_error(length_error), .stall_cycles(stall_cycles)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int fbytes(input logic p, input logic [3:0] l);
    if (!p) return 0;
    case (l)
      4'b0001: return 1;
      4'b0010: return 2;
      4'b0100, 4'b1000: return 4;
      default: return -1;
    endcase
  endfunction
  always @(posedge clock) begin
    int d, i;
    bit e;
    if (reset || flush) begin
      mq.delete();
      sb.delete();
      pop_n = 0;
      exp_err = 0;
    end else begin
      e = 0;
      repeat (pop_n) void'(mq.pop_front());
      pop_n = 0;
      if (fetch_valid) begin
        if (fetch_count >= 1 && fetch_count <= 4) begin
          if (fetch_ready) for (int k = 0; k < int'(fetch_count); k++) mq.push_back(fetch_bytes[8*k +: 8]);
        end else e = 1;
      end
      if (req_valid && req_ready) begin
        d = fbytes(displacement_is_present, displacement_length);
        i = fbytes(immediate_is_present, immediate_length);
        if (d < 0 || i < 0) e = 1;
        else sb.push_back(d + i);
      end
      exp_err = e;
    end
  end
  always @(negedge clock) begin
    int n;
    if (reset) begin
      hold_prev = 0;
      late = 0;
    end else begin
      chk("occupancy", 64'(occupancy), 64'(mq.size()));
      chk("fetch_ready", 64'(fetch_ready), 64'((DEPTH - mq.size()) >= 4));
      chk("req_ready", 64'(req_ready), 64'(sb.size() == 0));
      chk("length_error", 64'(length_error), 64'(exp_err));
      chk("spurious_win", 64'(win_valid && sb.size() == 0), 64'(0));
      if (hold_prev && win_valid) chk("window_hold", window, prev_win);
      late = (!win_valid && sb.size() > 0 && mq.size() >= sb[0]) ? late + 1 : 0;
      chk("present_latency", 64'(late > 1), 64'(0));
      if (win_valid && win_ready && !flush && sb.size() > 0) begin
        n = sb.pop_front();
        chk("window_need_held", 64'(mq.size() >= n), 64'(1));
        for (int k = 0; k < n; k++) chk("window_byte", 64'(window[8*k +: 8]), 64'(mq[k]));
        pop_n = n;
      end
      hold_prev = win_valid && !win_ready && !flush;
      prev_win = window;
    end
  end
  task automatic idle_inputs();
    flush = 0; fetch_valid = 0; fetch_bytes = '0; fetch_count = '0; req_valid = 0;
    displacement_is_present = 0; displacement_length = '0;
    immediate_is_present = 0; immediate_length = '0; win_ready = 0;
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic push(input logic [31:0] b, input logic [2:0] c);
    fetch_valid = 1; fetch_bytes = b; fetch_count = c;
  endtask
  task automatic req(input logic dp, input logic [3:0] dl, input logic ip, input logic [3:0] il);
    req_valid = 1; displacement_is_present = dp; displacement_length = dl;
    immediate_is_present = ip; immediate_length = il;
  endtask
  initial begin
    idle_inputs();
    reset = 1;
    repeat (3) step();
    reset = 0;
    chk("rst_occ", 64'(occupancy), 64'(0));
    chk("rst_win_valid", 64'(win_valid), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    chk("rst_window", window, 64'(0));
    chk("rst_len_err", 64'(length_error), 64'(0));
    chk("rst_stall", 64'(stall_cycles), 64'(0));
    push(32'h44332211, 3'd4); step(); idle_inputs();
    req(1, 4'b0001, 1, 4'b0010); step(); idle_inputs();
    chk("d8i16_win_valid", 64'(win_valid), 64'(1));
    chk("d8i16_window", window, 64'h44332211);
    win_ready = 1; step(); idle_inputs();
    chk("d8i16_occ_after", 64'(occupancy), 64'(1));
    chk("d8i16_head_after", window, 64'h44);
    flush = 1; step(); idle_inputs();
    chk("flush_occ", 64'(occupancy), 64'(0));
    req(1, 4'b0100, 1, 4'b0100); push(32'h04030201, 3'd4); step(); idle_inputs();
    chk("need8_wait1", 64'(win_valid), 64'(0));
    push(32'h08070605, 3'd4); step(); idle_inputs();
    chk("need8_wait2", 64'(win_valid), 64'(0));
    step();
    chk("need8_present", 64'(win_valid), 64'(1));
    chk("need8_window", window, 64'h0807060504030201);
`ifdef DECODE_SEQ_STALL_COUNT_EN
    chk("need8_stall", 64'(stall_cycles), 64'(2));
`else
    chk("need8_stall", 64'(stall_cycles), 64'(0));
`endif
    win_ready = 1; step(); idle_inputs();
    chk("need8_occ_after", 64'(occupancy), 64'(0));
    req(1, 4'b0001, 0, 4'b0000); push(32'hA4A3A2A1, 3'd4); step(); idle_inputs();
    chk("hold_present", 64'(win_valid), 64'(1));
    for (int i = 0; i < 3; i++) begin
      push(32'hB0B1B2B3 + 32'(i), i == 2 ? 3'd1 : 3'd4); step(); idle_inputs();
      chk("hold_window", window, 64'hA4A3A2A1);
      chk("hold_valid", 64'(win_valid), 64'(1));
      chk("hold_occ", 64'(occupancy), 64'(i == 2 ? 13 : 8 + 4 * i));
      chk("hold_fetch_ready", 64'(fetch_ready), 64'(i < 2));
    end
    win_ready = 1; step(); idle_inputs();
    chk("hold_occ_after", 64'(occupancy), 64'(12));
    flush = 1; step(); idle_inputs();
    req(1, 4'b0011, 0, 4'b0000); step(); idle_inputs();
    chk("illegal_err", 64'(length_error), 64'(1));
    chk("illegal_no_win", 64'(win_valid), 64'(0));
    chk("illegal_idle", 64'(req_ready), 64'(1));
    step();
    chk("illegal_err_pulse", 64'(length_error), 64'(0));
    chk("illegal_no_win2", 64'(win_valid), 64'(0));
    req(1, 4'b0001, 0, 4'b0000); push(32'h11111111, 3'd4); step(); idle_inputs();
    chk("flush_pre_valid", 64'(win_valid), 64'(1));
    flush = 1; push(32'h22222222, 3'd4); step(); idle_inputs();
    chk("flush_occ0", 64'(occupancy), 64'(0));
    chk("flush_win_drop", 64'(win_valid), 64'(0));
    chk("flush_req_ready", 64'(req_ready), 64'(1));
    push(32'h0000BBAA, 3'd2); step(); idle_inputs();
    req(0, 4'b0000, 0, 4'b0000); step(); idle_inputs();
    chk("need0_valid", 64'(win_valid), 64'(1));
    win_ready = 1; step(); idle_inputs();
    chk("need0_occ", 64'(occupancy), 64'(2));
    chk("need0_idle", 64'(win_valid), 64'(0));
    flush = 1; step(); idle_inputs();
    push(32'h12345678, 3'd0); step(); idle_inputs();
    chk("cnt0_err", 64'(length_error), 64'(1));
    chk("cnt0_occ", 64'(occupancy), 64'(0));
    push(32'h12345678, 3'd5); step(); idle_inputs();
    chk("cnt5_err", 64'(length_error), 64'(1));
    chk("cnt5_occ", 64'(occupancy), 64'(0));
    req(1, 4'b0001, 0, 4'b0000); push(32'h55667788, 3'd4); step(); idle_inputs();
    reset = 1; step(); reset = 0;
    chk("midrst_occ", 64'(occupancy), 64'(0));
    chk("midrst_valid", 64'(win_valid), 64'(0));
    chk("midrst_window", window, 64'(0));
    for (int c = 0; c < 3000; c++) begin
      idle_inputs();
      if ($urandom_range(0, 1) == 1)
        push($urandom, $urandom_range(0, 15) == 0 ? 3'($urandom_range(0, 1) * 5) : 3'($urandom_range(1, 4)));
      if ($urandom_range(0, 2) == 0) begin
        req_valid = 1;
        displacement_is_present = 1'($urandom_range(0, 1));
        immediate_is_present = 1'($urandom_range(0, 1));
        displacement_length = $urandom_range(0, 9) == 0 ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
        immediate_length = $urandom_range(0, 9) == 0 ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
      end
      win_ready = 1'($urandom_range(0, 1));
      flush = $urandom_range(0, 63) == 0;
      step();
    end
    idle_inputs();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
